uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Serializes bytes written by the CPU's memory-mapped IO port onto a UART TX line, 8N1 format, LSB first. Sits between the memory-mapped IO block's 8-bit transmit byte and the external TX pin. A small FIFO lets the CPU issue several stores without polling between bytes. Status outputs feed the memory-mapped read path, so software can poll `full`, `busy` and `overrun`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of 2, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: byte write strobe, one byte per cycle high.
- `wr_data` in 8: byte to transmit, sampled when `wr_en`=1.
- `clr_overrun` in 1: clears `overrun`.
- `tx` out 1: serial line, idle high.
- `full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `busy` out 1: high when a frame is in progress or the FIFO is non-empty.
- `overrun` out 1: sticky; a write was dropped.

## Operation
- FIFO push: `wr_en`=1 and not `full` → `wr_data` is stored.
- Write when full: `wr_en`=1 and `full`=1 → byte dropped and `overrun` set.
  - Applies even if a pop happens in the same cycle; `full` is the registered value.
- `overrun` clearing:
  - `clr_overrun`=1 clears `overrun` at the next edge.
  - If a drop occurs in the same cycle, set wins.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START: taken when the FIFO is non-empty.
  - Pop the head into an 8-bit shift register.
  - Clear the baud counter and the bit index.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit.
  - Shift right after each bit.
  - After bit index 7 completes, go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle:
  - FIFO non-empty → pop and go directly to START (no idle gap).
  - Otherwise → go to IDLE.
- Baud counter:
  - Width is clog2(`CLKS_PER_BIT`).
  - Counts 0..`CLKS_PER_BIT`-1, then wraps to 0 on each bit boundary.
- `tx` is registered and glitch-free.
- `full` is a registered count compare.
- `busy` = (state≠IDLE) | (count≠0).

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `tx`=1, `full`=0, `busy`=0, `overrun`=0.
  - FIFO empty, state IDLE, counters 0.
- Reset mid-frame aborts the frame; `tx` returns high at once and FIFO contents are discarded.
- Write-to-start latency:
  - Write at edge k into an empty FIFO in IDLE.
  - FIFO count = 1 after edge k; `busy`=1 after edge k.
  - Pop and START at edge k+1; `tx` falls after edge k+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles.
  - Back-to-back frames: next start bit immediately follows the stop bit.
- `busy` falls after the edge that ends the last stop bit with the FIFO empty.
- `full`: rises after the edge that makes the count equal `FIFO_DEPTH`; falls after the edge of the pop.

## Test plan
- Single frame:
  - Stimulus: `CLKS_PER_BIT`=4; write 0xA5 at edge k.
  - Response: `tx` low from k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles. `busy` is low after edge k+41.
- Back-to-back:
  - Stimulus: write 0x55 then 0x0F on consecutive cycles.
  - Response: two frames totalling 80 cycles with no idle cycle between them; second frame's data bits are 1,1,1,1,0,0,0,0.
- FIFO fill and overrun:
  - Stimulus: 6 consecutive writes 0x01..0x06.
  - Response: 0x01 pops at the edge after its write. 0x02–0x05 fill the FIFO and `full`=1. 0x06 is dropped and `overrun`=1. Serial output is 0x01..0x05.
- Overrun clear:
  - Stimulus: assert `clr_overrun` for one cycle.
  - Response: `overrun`=0 next cycle. With a simultaneous dropped write, `overrun` stays 1.
- Reset mid-frame:
  - Stimulus: drop `rst_n` during DATA bit 3 of 0xF0, with 2 bytes queued.
  - Response: `tx`=1, `busy`=0, `full`=0 immediately. No further frames after release.
- Write while full, same-cycle pop:
  - Stimulus: FIFO full; STOP ends and a write lands in the same cycle.
  - Response: write dropped, `overrun`=1, count becomes `FIFO_DEPTH`-1.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Byte FIFO plus 8N1 UART transmitter, LSB first. The CPU's memory-mapped
//   IO block pushes bytes. The transmitter drains them onto the TX pin with
//   no idle gap between queued frames.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_en        in   byte write strobe (one byte per cycle high)
//   wr_data[7:0] in   byte to transmit, sampled when wr_en=1
//   clr_overrun  in   clears the sticky overrun flag
//   tx           out  serial line, idle high, registered
//   full         out  FIFO holds FIFO_DEPTH bytes (registered)
//   busy         out  frame in progress or FIFO non-empty
//   overrun      out  sticky, a write was dropped
//   o_dbg_state  out  current transmitter state (IDLE/START/DATA/STOP)
//
// Handshake: wr_en is a valid-only strobe. The registered full flag acts as
// the inverted ready. A write with full=1 is dropped and sets overrun, even
// if the transmitter pops in the same cycle.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       clr_overrun,
   output logic       tx,
   output logic       full,
   output logic       busy,
   output logic       overrun,
   output logic [1:0] o_dbg_state
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_overrun;

   logic          w_bit_done;
   logic          w_fifo_nempty;
   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_count_next;

   assign w_bit_done    = (r_baud == BAUD_LAST);
   assign w_fifo_nempty = (r_count != '0);
   assign w_push        = wr_en & ~r_full;
   // Pop when leaving IDLE, or on the last stop-bit cycle to chain frames.
   assign w_pop         = w_fifo_nempty &
                          ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_done));

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Storage has no reset. Pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_full  <= (w_count_next == DEPTH);
         // A drop in the same cycle as a clear wins.
         if (wr_en && r_full) begin
            r_overrun <= 1'b1;
         end else if (clr_overrun) begin
            r_overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift   <= r_mem[r_rd_ptr];
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= 1'b0;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               if (w_bit_done) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= ST_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            ST_DATA: begin
               if (w_bit_done) begin
                  r_baud  <= '0;
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= ST_STOP;
                  end else begin
                     // The next bit is shift[1] before the shift lands.
                     r_tx      <= r_shift[1];
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            ST_STOP: begin
               if (w_bit_done) begin
                  r_baud <= '0;
                  if (w_pop) begin
                     r_shift   <= r_mem[r_rd_ptr];
                     r_bit_idx <= '0;
                     r_tx      <= 1'b0;
                     r_state   <= ST_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx          = r_tx;
   assign full        = r_full;
   assign overrun     = r_overrun;
   assign busy        = (r_state != ST_IDLE) | w_fifo_nempty;
   assign o_dbg_state = r_state;

endmodule
